// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   alu_op_e          - 4-bit opcode encoding used on the sel port
//   alu_state_e       - sequencer states (IDLE, MUL_RUN, DONE)
//   ALU_ILLEGAL_FIRST - first opcode value that is never supported
// Optional feature macro: ALU_MUL_EN (see alu_seq_unit).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLA = 4'd6,
    OP_SLL = 4'd7,
    OP_SRA = 4'd8,
    OP_SRL = 4'd9,
    OP_MUL = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } alu_state_e;

  localparam logic [3:0] ALU_ILLEGAL_FIRST = 4'd11;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU operations and flag generation.
// Ports:
//   a, b      in  WIDTH : operands; b[SHW-1:0] is the shift amount for shifts
//   sel       in  4     : opcode (alu_op_e encoding)
//   result    out WIDTH : operation result (0 for unsupported opcodes)
//   cout      out 1     : carry out (ADD only)
//   negative  out 1     : a<b for SUB, result MSB otherwise
//   zero      out 1     : result == 0
//   illegal   out 1     : opcode not handled here (includes MUL, which the
//                         sequencer handles itself when ALU_MUL_EN is defined)
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             negative,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0]          n_s;
  logic [WIDTH:0]          sum_s;
  logic signed [WIDTH-1:0] a_sgn_s;

  assign n_s     = b[SHW-1:0];
  assign sum_s   = {1'b0, a} + {1'b0, b};
  assign a_sgn_s = a;

  // Opcode decode, result selection and flag generation.
  always_comb begin
    result  = '0;
    cout    = 1'b0;
    illegal = 1'b0;
    if (sel >= ALU_ILLEGAL_FIRST) begin
      illegal = 1'b1;
    end else begin
      case (sel)
        OP_ADD: begin
          result = sum_s[WIDTH-1:0];
          cout   = sum_s[WIDTH];
        end
        OP_SUB:  result = (a >= b) ? (a - b) : (b - a);
        OP_NOT:  result = ~a;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_SLA:  result = a << n_s;
        OP_SLL:  result = a << n_s;
        OP_SRA:  result = a_sgn_s >>> n_s;
        OP_SRL:  result = a >> n_s;
        default: illegal = 1'b1;
      endcase
    end
    // SUB reports magnitude, so its sign comes from the unsigned compare.
    if (illegal) begin
      negative = 1'b0;
    end else if (sel == OP_SUB) begin
      negative = (a < b);
    end else begin
      negative = result[WIDTH-1];
    end
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with registered output stage.
// Ports:
//   clk, rst_n           : rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  : operation handshake (transfer on valid && ready)
//   a, b, sel            : operands and opcode, captured at transfer
//   out_valid / out_ready: result handshake; outputs hold under backpressure
//   result, cout, negative, zero, illegal : registered result and flags
// Macro ALU_MUL_EN: when defined, opcode 10 runs a WIDTH-cycle shift-add
// multiplier through the MUL_RUN/DONE states; when undefined, opcode 10 is
// illegal and the unit has no sequencer state.
import alu_pkg::*;

module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             negative,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] core_result_s;
  logic             core_cout_s;
  logic             core_negative_s;
  logic             core_zero_s;
  logic             core_illegal_s;
  logic             out_free_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_load_s;
  logic [WIDTH-1:0] mul_result_s;
  logic             mul_cout_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .sel      (sel),
    .result   (core_result_s),
    .cout     (core_cout_s),
    .negative (core_negative_s),
    .zero     (core_zero_s),
    .illegal  (core_illegal_s)
  );

  // Output stage can take a new value when empty or being drained this edge.
  assign out_free_s = !out_valid || out_ready;
  assign accept_s   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  alu_state_e         state_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;

  assign in_ready     = (state_r == ST_IDLE) && out_free_s;
  assign is_mul_s     = (sel == OP_MUL);
  assign mul_load_s   = (state_r == ST_DONE);
  assign mul_result_s = acc_r[WIDTH-1:0];
  assign mul_cout_s   = |acc_r[2*WIDTH-1:WIDTH];

  // Sequencer and shift-add multiplier: one partial product per MUL_RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= ST_MUL_RUN;
          end
        end
        ST_MUL_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= ST_DONE;
          end
        end
        // Output stage is always empty here: nothing else can load it
        // while the multiplier owns the unit.
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready     = out_free_s;
  assign is_mul_s     = 1'b0;
  assign mul_load_s   = 1'b0;
  assign mul_result_s = '0;
  assign mul_cout_s   = 1'b0;
`endif

  // Output registers: load finished MUL or accepted single-cycle op, else drain/hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (mul_load_s) begin
      out_valid <= 1'b1;
      result    <= mul_result_s;
      cout      <= mul_cout_s;
      negative  <= mul_result_s[WIDTH-1];
      zero      <= (mul_result_s == '0);
      illegal   <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid <= 1'b1;
      result    <= core_result_s;
      cout      <= core_cout_s;
      negative  <= core_negative_s;
      zero      <= core_zero_s;
      illegal   <= core_illegal_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed, table-driven bench for alu_seq_unit at WIDTH=4.
// Expected values are hand-computed; the MUL expectations follow ALU_MUL_EN.
import alu_pkg::*;

module tb_alu_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [3:0] sel = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] result;
  logic       cout;
  logic       negative;
  logic       zero;
  logic       illegal;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       n;
    logic       z;
    logic       i;
  } vec_t;

  vec_t vecs[$];

  alu_seq_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .negative  (negative),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {out_valid, result, cout, negative, zero, illegal};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] s, input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] r, input logic c, input logic n,
                         input logic z, input logic i);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.res = r; v.c = c; v.n = n; v.z = z; v.i = i;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    //            sel      a        b        res      c     n     z     i
    add_vec(4'd0,  4'd14,   4'd5,    4'd3,    1'b1, 1'b0, 1'b0, 1'b0); // ADD carry
    add_vec(4'd1,  4'd6,    4'd10,   4'd4,    1'b0, 1'b1, 1'b0, 1'b0); // SUB a<b
    add_vec(4'd1,  4'd6,    4'd6,    4'd0,    1'b0, 1'b0, 1'b1, 1'b0); // SUB equal
    add_vec(4'd8,  4'b1010, 4'd1,    4'b1101, 1'b0, 1'b1, 1'b0, 1'b0); // SRA
    add_vec(4'd8,  4'b1110, 4'd3,    4'b1111, 1'b0, 1'b1, 1'b0, 1'b0); // SRA by 3
    add_vec(4'd9,  4'b1110, 4'd1,    4'b0111, 1'b0, 1'b0, 1'b0, 1'b0); // SRL
    add_vec(4'd7,  4'b1110, 4'd2,    4'b1000, 1'b0, 1'b1, 1'b0, 1'b0); // SLL
    add_vec(4'd6,  4'b0011, 4'd1,    4'b0110, 1'b0, 1'b0, 1'b0, 1'b0); // SLA
    add_vec(4'd9,  4'b1010, 4'b0100, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0); // SRL amount = b[1:0] = 0
    add_vec(4'd2,  4'b0101, 4'd0,    4'b1010, 1'b0, 1'b1, 1'b0, 1'b0); // NOT
    add_vec(4'd3,  4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0); // AND
    add_vec(4'd4,  4'b0001, 4'b0100, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0); // OR
    add_vec(4'd5,  4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0); // XOR to zero
    add_vec(4'd0,  4'd8,    4'd8,    4'd0,    1'b1, 1'b0, 1'b1, 1'b0); // ADD wrap to zero
    add_vec(4'd13, 4'd9,    4'd3,    4'd0,    1'b0, 1'b0, 1'b1, 1'b1); // illegal opcode
    add_vec(4'd11, 4'd1,    4'd1,    4'd0,    1'b0, 1'b0, 1'b1, 1'b1); // first illegal
`ifndef ALU_MUL_EN
    add_vec(4'd10, 4'd7,    4'd3,    4'd0,    1'b0, 1'b0, 1'b1, 1'b1); // MUL without macro
`endif

    // Reset held for two edges.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {7'd0, obs()}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", {14'd0, out_valid, in_ready}, 16'd1);

    // Back-to-back table, one op per cycle with out_ready high.
    for (int i = 0; i < vecs.size(); i++) begin
      a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel; in_valid = 1'b1;
      check($sformatf("vec%0d_ready", i), {15'd0, in_ready}, 16'd1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), {7'd0, obs()},
            {7'd0, 1'b1, vecs[i].res, vecs[i].c, vecs[i].n, vecs[i].z, vecs[i].i});
    end
    in_valid = 1'b0;

    // MUL 7x3; operands scrambled after accept.
    a = 4'd7; b = 4'd3; sel = 4'd10; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 4'hF; b = 4'hF; sel = 4'd0;
`ifdef ALU_MUL_EN
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mul_busy%0d", k), {14'd0, in_ready, out_valid}, 16'd0);
      @(posedge clk);
      #1;
    end
    check("mul_result", {7'd0, obs()}, {7'd0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0});
`else
    check("mul_illegal", {7'd0, obs()}, {7'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1});
`endif

    // AND overwrites the pending result on the same edge, then backpressure.
    a = 4'b1010; b = 4'b0110; sel = 4'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    a = 4'b0001; b = 4'b0010; sel = 4'd4;
    check("bp_load", {7'd0, obs()}, {7'd0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", k), {6'd0, in_ready, obs()},
            {6'd0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_op", {7'd0, obs()}, {7'd0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset during the second cycle of a MUL.
    @(posedge clk);
    #1;
    a = 4'd7; b = 4'd3; sel = 4'd10; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midmul_reset", {14'd0, out_valid, in_ready}, 16'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midmul_no_result", {15'd0, seen}, 16'd0);
    a = 4'd2; b = 4'd5; sel = 4'd0; in_valid = 1'b1;
    #1;
    check("midmul_idle_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_reset_add", {7'd0, obs()}, {7'd0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the combinational 4-bit ALU (`mod_alu`). It accepts one operation per transfer on a valid/ready input port and registers result and flags into an output stage held under backpressure. It generalises data width, adds variable shift amounts and adds an optional multi-cycle shift-add multiplier. It sits between the operand/decode logic and the register writeback path in the lab datapath.

## Interface
- `WIDTH`, 8, operand/result width; legal range 2..32.
- `SHW`, `$clog2(WIDTH)`, shift-amount field width (derived, not overridden).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept; transfer occurs when `in_valid && in_ready`.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B; low SHW bits give the shift amount for shift ops.
- `sel` in 4: opcode.
- `out_valid` out 1: result registers hold a result.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: registered result.
- `cout` out 1: registered carry/overflow.
- `negative` out 1: registered negative flag.
- `zero` out 1: registered zero flag.
- `illegal` out 1: registered flag; opcode not supported.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 NOT a, 3 AND, 4 OR, 5 XOR, 6 SLA, 7 SLL, 8 SRA, 9 SRL, 10 MUL (macro only). 11..15 are illegal.
- ADD: `result = (a+b)[WIDTH-1:0]`; `cout` = carry out; `negative` = result MSB.
- SUB: `result = |a-b|` (unsigned magnitude); `negative = (a<b)` unsigned; `cout = 0`.
- Logic ops and shifts: `cout = 0`; `negative` = result MSB.
- Shifts use amount `n = b[SHW-1:0]`.
  - SLA and SLL are identical: zero-fill left.
  - SRA replicates `a[WIDTH-1]`; SRL zero-fills.
- MUL: unsigned shift-add over WIDTH iterations.
  - `result` = low WIDTH bits of the product.
  - `cout = 1` if any high product bit is set.
- All ops: `zero = (result == 0)`.
- Illegal opcode: `result = 0`, `zero = 1`, `illegal = 1`, all other flags 0. It is still delivered as a normal single-cycle result.
- FSM states:
  - IDLE → MUL_RUN when a MUL is accepted.
  - MUL_RUN → DONE after WIDTH iteration cycles.
  - DONE → IDLE on the cycle the result is loaded into the output stage.
  - All other ops are handled in IDLE.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`.

## Timing
- Reset values: `out_valid = 0`, `result = 0`, `cout = 0`, `negative = 0`, `zero = 0`, `illegal = 0`, state IDLE, `in_ready = 1` in the cycle after reset deasserts.
- Single-cycle ops: accepted at edge k, `out_valid = 1` with the result after edge k. Full throughput of one op per cycle while `out_ready = 1`.
- MUL: accepted at edge k, `out_valid` rises after edge k+WIDTH+1. `in_ready = 0` throughout.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable and `in_ready = 0`.
- Simultaneous `out_ready` and new accept: the output stage is overwritten by the new op in the same edge, with no bubble.
- Reset mid-MUL: the operation is discarded, the FSM returns to IDLE and no result is emitted.
- Operands are captured at accept; later changes to `a`, `b` or `sel` have no effect.

## Configuration
- `ALU_MUL_EN` defined: the MUL opcode, MUL_RUN/DONE states and multiplier datapath are compiled in.
- `ALU_MUL_EN` undefined: opcode 10 is treated as illegal, the FSM is reduced to IDLE, and `in_ready = !out_valid || out_ready`.

## Structure
- Package `alu_pkg` holds:
  - an opcode enum `alu_op_e` (4 bits, values above);
  - a state enum `alu_state_e`;
  - the `ALU_ILLEGAL_FIRST = 11` constant.
- Sub-module `alu_core`: purely combinational single-cycle ops plus flag generation, parametrised by WIDTH.
- `alu_seq_unit` owns the handshake, FSM, multiplier accumulator/counter and output registers.

## Test plan
All scenarios use WIDTH=4.
- Reset low for 2 cycles → all outputs 0, `in_ready = 1`. ADD 14+5 → `result = 3`, `cout = 1`, one cycle later.
- SUB 6−10 → `result = 4`, `negative = 1`. SUB 6−6 → `result = 0`, `zero = 1`. Both back-to-back with `out_ready = 1`, one result per cycle.
- SRA 1010 with `b = 1` → 1101. SRA 1110 with `b = 3` → 1111. SRL 1110 with `b = 1` → 0111. SLL 1110 with `b = 2` → 1000.
- MUL 7×3 (macro on) → `in_ready = 0` for 5 cycles, then `result = 0101`, `cout = 1`. Macro off → `illegal = 1`, `zero = 1`.
- Hold `out_ready = 0` for 3 cycles after an AND of 1010 and 0110 → 0010 held stable, `in_ready = 0`. Release → the next queued op is accepted on the same edge.
- Assert `rst_n = 0` at cycle 2 of a MUL → no `out_valid`, FSM back in IDLE, the next ADD of 2+5 → 0111.
